// File: rtl/rv_operand_fetch.sv
// rv_operand_fetch
//   RV32I decode / operand-fetch stage sitting between instruction fetch and
//   execute. Decodes the opcode class, drives the register file read ports,
//   forwards the same-cycle writeback, tracks outstanding destinations in a
//   busy scoreboard for RAW/WAW stalls, builds the immediate and presents a
//   registered ID/EX entry.
//
// Ports
//   iClk, nRst              clock (rising edge), async active-low reset
//   iValid / oReady         upstream handshake, iInstr / iPC payload
//   oAddrA / oAddrB         register file read addresses (combinational)
//   iRegA / iRegB           register file read data
//   iWbWrite/iWbAddr/iWbData writeback port (also clears scoreboard)
//   iFlush                  kill ID/EX entry and refuse input this cycle
//   oValid / iReady         downstream handshake
//   oPC, oInstr, oOpA, oOpB, oImm, oRd, oRdWrite, oIllegal  ID/EX entry
module rv_operand_fetch #(
  parameter int unsigned XLEN      = 32,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic            iClk,
  input  logic            nRst,
  input  logic            iValid,
  output logic            oReady,
  input  logic [31:0]     iInstr,
  input  logic [XLEN-1:0] iPC,
  output logic [4:0]      oAddrA,
  output logic [4:0]      oAddrB,
  input  logic [XLEN-1:0] iRegA,
  input  logic [XLEN-1:0] iRegB,
  input  logic            iWbWrite,
  input  logic [4:0]      iWbAddr,
  input  logic [XLEN-1:0] iWbData,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oPC,
  output logic [31:0]     oInstr,
  output logic [XLEN-1:0] oOpA,
  output logic [XLEN-1:0] oOpB,
  output logic [XLEN-1:0] oImm,
  output logic [4:0]      oRd,
  output logic            oRdWrite,
  output logic            oIllegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = iInstr[6:0];
  assign rs1    = iInstr[19:15];
  assign rs2    = iInstr[24:20];
  assign rd     = iInstr[11:7];

  assign oAddrA = rs1;
  assign oAddrB = rs2;

  // ---------------------------------------------------------------------------
  // Immediate formats
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = {{20{iInstr[31]}}, iInstr[31:20]};
  assign imm_s = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
  assign imm_b = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25],
                  iInstr[11:8], 1'b0};
  assign imm_u = {iInstr[31:12], 12'h000};
  assign imm_j = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20],
                  iInstr[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Opcode class decode
  // ---------------------------------------------------------------------------
  logic            use_rs1;
  logic            use_rs2;
  logic            has_rd;
  logic            illegal;
  logic [XLEN-1:0] imm;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        has_rd  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        imm     = imm_i;
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = imm_s;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        has_rd = 1'b1;
        imm    = imm_u;
      end
      OP_JAL: begin
        has_rd = 1'b1;
        imm    = imm_j;
      end
      default: illegal = 1'b1;
    endcase
  end

  // x0 is never a real dependency nor a real destination.
  logic src_a_live;
  logic src_b_live;
  logic rd_write;

  assign src_a_live = use_rs1 && (rs1 != 5'd0);
  assign src_b_live = use_rs2 && (rs2 != 5'd0);
  assign rd_write   = has_rd && (rd != 5'd0);

  // ---------------------------------------------------------------------------
  // Scoreboard lookup, bypass and hazard
  // ---------------------------------------------------------------------------
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  logic wb_clr;
  logic byp_a;
  logic byp_b;
  logic stall_a;
  logic stall_b;
  logic waw;
  logic hazard;
  logic ready;
  logic load;

  assign wb_clr = iWbWrite && (iWbAddr != 5'd0);

  assign byp_a = BYPASS_EN && iWbWrite && (iWbAddr == rs1);
  assign byp_b = BYPASS_EN && iWbWrite && (iWbAddr == rs2);

  assign stall_a = src_a_live && busy_q[rs1] && !byp_a;
  assign stall_b = src_b_live && busy_q[rs2] && !byp_b;

  // A writeback landing on rd this cycle retires the older writer, so the
  // new one may claim the register without waiting.
  assign waw = rd_write && busy_q[rd] && !(iWbWrite && (iWbAddr == rd));

  assign hazard = iValid && (stall_a || stall_b || waw);
  assign ready  = !iFlush && !hazard && (!oValid || iReady);
  assign load   = iValid && ready;
  assign oReady = ready;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  assign op_a = !src_a_live ? '0 : (byp_a ? iWbData : iRegA);
  assign op_b = !src_b_live ? '0 : (byp_b ? iWbData : iRegB);

  // ---------------------------------------------------------------------------
  // ID/EX entry
  // ---------------------------------------------------------------------------
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic            rdw_q, rdw_d;
  logic            ill_q, ill_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rdw_d   = rdw_q;
    ill_d   = ill_q;
    if (iFlush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = iPC;
      instr_d = iInstr;
      opa_d   = op_a;
      opb_d   = op_b;
      imm_d   = imm;
      rd_d    = has_rd ? rd : 5'd0;
      rdw_d   = rd_write;
      ill_d   = illegal;
    end else if (iReady) begin
      valid_d = 1'b0;
    end
  end

  // A flushed entry never reaches writeback, so its claim on rd is dropped.
  logic kill_rd;
  assign kill_rd = iFlush && valid_q && rdw_q;

  // Ordering gives the required priorities: load-set beats writeback-clear,
  // flush-clear beats everything.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr) begin
      busy_d[iWbAddr] = 1'b0;
    end
    if (load && rd_write) begin
      busy_d[rd] = 1'b1;
    end
    if (kill_rd) begin
      busy_d[rd_q] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rdw_q   <= 1'b0;
      ill_q   <= 1'b0;
      busy_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rdw_q   <= rdw_d;
      ill_q   <= ill_d;
      busy_q  <= busy_d;
    end
  end

  assign oValid   = valid_q;
  assign oPC      = pc_q;
  assign oInstr   = instr_q;
  assign oOpA     = opa_q;
  assign oOpB     = opb_q;
  assign oImm     = imm_q;
  assign oRd      = rd_q;
  assign oRdWrite = rdw_q;
  assign oIllegal = ill_q;

endmodule

// File: tb/tb_rv_operand_fetch.sv
module tb_rv_operand_fetch;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iValid;
  logic [31:0] iInstr;
  logic [31:0] iPC;
  logic [31:0] iRegA;
  logic [31:0] iRegB;
  logic        iWbWrite;
  logic [4:0]  iWbAddr;
  logic [31:0] iWbData;
  logic        iFlush;
  logic        iReady;

  logic        oReady, oValid, oRdWrite, oIllegal;
  logic [4:0]  oAddrA, oAddrB, oRd;
  logic [31:0] oPC, oInstr, oOpA, oOpB, oImm;

  logic        nb_oReady, nb_oValid, nb_oRdWrite, nb_oIllegal;
  logic [4:0]  nb_oAddrA, nb_oAddrB, nb_oRd;
  logic [31:0] nb_oPC, nb_oInstr, nb_oOpA, nb_oOpB, nb_oImm;

  int n_checks = 0;
  int n_errors = 0;

  always #5 iClk = ~iClk;

  rv_operand_fetch #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
    .iClk(iClk), .nRst(nRst), .iValid(iValid), .oReady(oReady),
    .iInstr(iInstr), .iPC(iPC), .oAddrA(oAddrA), .oAddrB(oAddrB),
    .iRegA(iRegA), .iRegB(iRegB), .iWbWrite(iWbWrite), .iWbAddr(iWbAddr),
    .iWbData(iWbData), .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oPC(oPC), .oInstr(oInstr), .oOpA(oOpA), .oOpB(oOpB), .oImm(oImm),
    .oRd(oRd), .oRdWrite(oRdWrite), .oIllegal(oIllegal)
  );

  rv_operand_fetch #(.XLEN(32), .BYPASS_EN(1'b0)) dut_nb (
    .iClk(iClk), .nRst(nRst), .iValid(iValid), .oReady(nb_oReady),
    .iInstr(iInstr), .iPC(iPC), .oAddrA(nb_oAddrA), .oAddrB(nb_oAddrB),
    .iRegA(iRegA), .iRegB(iRegB), .iWbWrite(iWbWrite), .iWbAddr(iWbAddr),
    .iWbData(iWbData), .iFlush(iFlush), .oValid(nb_oValid), .iReady(iReady),
    .oPC(nb_oPC), .oInstr(nb_oInstr), .oOpA(nb_oOpA), .oOpB(nb_oOpB),
    .oImm(nb_oImm), .oRd(nb_oRd), .oRdWrite(nb_oRdWrite),
    .oIllegal(nb_oIllegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nRst     = 1'b0;
    iValid   = 1'b0;
    iFlush   = 1'b0;
    iWbWrite = 1'b0;
    iWbAddr  = 5'd0;
    iWbData  = 32'd0;
    iReady   = 1'b1;
    @(posedge iClk);
    #1;
    nRst = 1'b1;
  endtask

  task automatic edge1();
    @(posedge iClk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: decoded by instruction class, scoreboard as a bit array
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rs1_used;
    bit          rs2_used;
    bit          writes;
    logic [31:0] imm;
    bit          ill;
  } dec_t;

  typedef struct {
    logic [31:0] pc, instr, opa, opb, imm;
    logic [4:0]  rd;
    logic        rdw, ill;
  } entry_t;

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    d.rs1_used = 0; d.rs2_used = 0; d.writes = 0; d.imm = 32'd0; d.ill = 0;
    case (ins[6:0])
      7'b0110011: begin d.rs1_used = 1; d.rs2_used = 1; d.writes = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        d.rs1_used = 1; d.writes = 1;
        d.imm = int'($signed(ins[31:20]));
      end
      7'b0100011: begin
        d.rs1_used = 1; d.rs2_used = 1;
        d.imm = int'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        d.rs1_used = 1; d.rs2_used = 1;
        d.imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        d.writes = 1;
        d.imm = {ins[31:12], 12'h000};
      end
      7'b1101111: begin
        d.writes = 1;
        d.imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      default: d.ill = 1;
    endcase
    if (ins[19:15] == 5'd0) d.rs1_used = 0;
    if (ins[24:20] == 5'd0) d.rs2_used = 0;
    if (ins[11:7] == 5'd0) d.writes = 0;
    return d;
  endfunction

  entry_t      m_e;
  bit          m_valid;
  bit          m_busy[32];
  logic [31:0] m_regs[32];

  task automatic model_reset();
    m_valid = 0;
    m_e = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
    for (int k = 0; k < 32; k++) m_busy[k] = 0;
  endtask

  // Inputs are already applied; check combinational outputs mid-cycle,
  // advance the model on the edge, then check the registered entry.
  task automatic model_cycle();
    dec_t       d;
    logic [4:0] s1, s2, rd;
    bit         hz, rdy, ld;
    entry_t     ne;
    d  = ref_decode(iInstr);
    s1 = iInstr[19:15];
    s2 = iInstr[24:20];
    rd = iInstr[11:7];
    hz = 0;
    if (d.rs1_used && m_busy[s1] && !(iWbWrite && iWbAddr == s1)) hz = 1;
    if (d.rs2_used && m_busy[s2] && !(iWbWrite && iWbAddr == s2)) hz = 1;
    if (d.writes && m_busy[rd] && !(iWbWrite && iWbAddr == rd)) hz = 1;
    rdy = !iFlush && !(iValid && hz) && (!m_valid || iReady);
    ld  = iValid && rdy;
    ne.pc    = iPC;
    ne.instr = iInstr;
    ne.opa   = !d.rs1_used ? 32'd0 : ((iWbWrite && iWbAddr == s1) ? iWbData : iRegA);
    ne.opb   = !d.rs2_used ? 32'd0 : ((iWbWrite && iWbAddr == s2) ? iWbData : iRegB);
    ne.imm   = d.imm;
    ne.rd    = d.writes ? rd : 5'd0;
    ne.rdw   = d.writes;
    ne.ill   = d.ill;
    @(negedge iClk);
    chk1("rnd_ready", oReady, rdy);
    chk5("rnd_addrA", oAddrA, s1);
    chk5("rnd_addrB", oAddrB, s2);
    @(posedge iClk);
    if (iWbWrite && iWbAddr != 5'd0) begin
      m_busy[iWbAddr] = 0;
      m_regs[iWbAddr] = iWbData;
    end
    if (ld && d.writes) m_busy[rd] = 1;
    if (iFlush) begin
      if (m_valid && m_e.rdw) m_busy[m_e.rd] = 0;
      m_valid = 0;
    end else if (ld) begin
      m_e = ne;
      m_valid = 1;
    end else if (iReady) begin
      m_valid = 0;
    end
    #1;
    chk1("rnd_valid", oValid, m_valid);
    chk("rnd_pc", oPC, m_e.pc);
    chk("rnd_instr", oInstr, m_e.instr);
    chk("rnd_opa", oOpA, m_e.opa);
    chk("rnd_opb", oOpB, m_e.opb);
    chk("rnd_imm", oImm, m_e.imm);
    chk5("rnd_rd", oRd, m_e.rd);
    chk1("rnd_rdw", oRdWrite, m_e.rdw);
    chk1("rnd_ill", oIllegal, m_e.ill);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: single instruction into an idle stage
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr, pc, ra, rb, opa, opb, imm;
    logic [4:0]  rd;
    logic        rdw, ill;
  } vec_t;

  vec_t        tv[11];
  logic [6:0]  op_tab[11];

  initial begin
    nRst = 1'b0; iValid = 1'b0; iInstr = 32'd0; iPC = 32'd0;
    iRegA = 32'd0; iRegB = 32'd0; iWbWrite = 1'b0; iWbAddr = 5'd0;
    iWbData = 32'd0; iFlush = 1'b0; iReady = 1'b1;

    tv[0]  = '{32'h00500093, 32'h100, 32'hAAAA0000, 32'hBBBB0000, 32'h0, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0};
    tv[1]  = '{32'hFE21AE23, 32'h104, 32'h200, 32'h7, 32'h200, 32'h7, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
    tv[2]  = '{32'h00108133, 32'h108, 32'h11, 32'h11, 32'h11, 32'h11, 32'h0, 5'd2, 1'b1, 1'b0};
    tv[3]  = '{32'hABCDE2B7, 32'h10C, 32'h5, 32'h6, 32'h0, 32'h0, 32'hABCDE000, 5'd5, 1'b1, 1'b0};
    tv[4]  = '{32'hFE208CE3, 32'h110, 32'h3, 32'h4, 32'h3, 32'h4, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b0};
    tv[5]  = '{32'hFFDFF06F, 32'h114, 32'h9, 32'h9, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
    tv[6]  = '{32'hFFFFFFFF, 32'h118, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
    tv[7]  = '{32'h00C381E7, 32'h11C, 32'h1234, 32'hDEAD, 32'h1234, 32'h0, 32'hC, 5'd3, 1'b1, 1'b0};
    tv[8]  = '{32'h00628033, 32'h120, 32'h1, 32'h2, 32'h1, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0};
    tv[9]  = '{32'h80000517, 32'h124, 32'h3, 32'h3, 32'h0, 32'h0, 32'h80000000, 5'd10, 1'b1, 1'b0};
    tv[10] = '{32'hFFF12303, 32'h128, 32'h40, 32'h50, 32'h40, 32'h0, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0};

    op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111,
               7'b1111111};

    // Reset state
    #2;
    iFlush = 1'b1; #1;
    chk1("rst_ready_flush", oReady, 1'b0);
    iFlush = 1'b0; #1;
    chk1("rst_ready", oReady, 1'b1);
    chk1("rst_valid", oValid, 1'b0);
    chk("rst_pc", oPC, 32'd0);
    chk("rst_instr", oInstr, 32'd0);
    chk("rst_imm", oImm, 32'd0);
    chk5("rst_rd", oRd, 5'd0);
    chk1("rst_rdw", oRdWrite, 1'b0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      do_reset();
      iValid = 1'b1; iInstr = tv[i].instr; iPC = tv[i].pc;
      iRegA = tv[i].ra; iRegB = tv[i].rb; iReady = 1'b1;
      @(negedge iClk);
      chk1("tv_ready", oReady, 1'b1);
      chk5("tv_addrA", oAddrA, tv[i].instr[19:15]);
      chk5("tv_addrB", oAddrB, tv[i].instr[24:20]);
      edge1();
      iValid = 1'b0;
      chk1("tv_valid", oValid, 1'b1);
      chk("tv_pc", oPC, tv[i].pc);
      chk("tv_instr", oInstr, tv[i].instr);
      chk("tv_opa", oOpA, tv[i].opa);
      chk("tv_opb", oOpB, tv[i].opb);
      chk("tv_imm", oImm, tv[i].imm);
      chk5("tv_rd", oRd, tv[i].rd);
      chk1("tv_rdw", oRdWrite, tv[i].rdw);
      chk1("tv_ill", oIllegal, tv[i].ill);
    end

    // RAW stall released by same-cycle writeback bypass, then WAW
    do_reset();
    iValid = 1'b1; iInstr = 32'h00500093; iPC = 32'h100; iRegA = 0; iRegB = 0;
    edge1();
    chk1("a_valid", oValid, 1'b1);
    chk("a_opa", oOpA, 32'd0);
    chk("a_imm", oImm, 32'd5);
    chk5("a_rd", oRd, 5'd1);
    chk1("a_rdw", oRdWrite, 1'b1);
    iInstr = 32'h00108133; iPC = 32'h104;
    @(negedge iClk);
    chk1("a_raw_stall", oReady, 1'b0);
    edge1();
    chk1("a_drain", oValid, 1'b0);
    iWbWrite = 1'b1; iWbAddr = 5'd1; iWbData = 32'd5;
    @(negedge iClk);
    chk1("a_bypass_ready", oReady, 1'b1);
    edge1();
    iWbWrite = 1'b0;
    chk1("a_add_valid", oValid, 1'b1);
    chk("a_add_opa", oOpA, 32'd5);
    chk("a_add_opb", oOpB, 32'd5);
    chk5("a_add_rd", oRd, 5'd2);
    iInstr = 32'h00100113; iPC = 32'h108;
    @(negedge iClk);
    chk1("a_waw_stall", oReady, 1'b0);
    iWbWrite = 1'b1; iWbAddr = 5'd2; iWbData = 32'd9;
    #1;
    chk1("a_waw_release", oReady, 1'b1);
    edge1();
    iWbWrite = 1'b0; iValid = 1'b0;
    chk("a_waw_instr", oInstr, 32'h00100113);

    // Same hazard without bypass: one extra stall cycle
    do_reset();
    iValid = 1'b1; iInstr = 32'h00500093; iPC = 32'h100; iRegA = 0; iRegB = 0;
    edge1();
    iInstr = 32'h00108133; iPC = 32'h104;
    iWbWrite = 1'b1; iWbAddr = 5'd1; iWbData = 32'd5;
    @(negedge iClk);
    chk1("b_nb_stall", nb_oReady, 1'b0);
    chk1("b_byp_ready", oReady, 1'b1);
    edge1();
    iWbWrite = 1'b0; iRegA = 32'd5; iRegB = 32'd5;
    @(negedge iClk);
    chk1("b_nb_ready", nb_oReady, 1'b1);
    edge1();
    iValid = 1'b0;
    chk1("b_nb_valid", nb_oValid, 1'b1);
    chk("b_nb_opa", nb_oOpA, 32'd5);
    chk("b_nb_opb", nb_oOpB, 32'd5);

    // Backpressure holds the entry
    do_reset();
    iReady = 1'b0;
    iValid = 1'b1; iInstr = 32'h00500093; iPC = 32'h100; iRegA = 0; iRegB = 0;
    edge1();
    chk1("d_valid", oValid, 1'b1);
    iInstr = 32'hABCDE2B7; iPC = 32'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge iClk);
      chk1("d_hold_ready", oReady, 1'b0);
      edge1();
      chk1("d_hold_valid", oValid, 1'b1);
      chk("d_hold_instr", oInstr, 32'h00500093);
      chk("d_hold_pc", oPC, 32'h100);
    end
    iReady = 1'b1;
    @(negedge iClk);
    chk1("d_release_ready", oReady, 1'b1);
    edge1();
    iValid = 1'b0;
    chk("d_new_instr", oInstr, 32'hABCDE2B7);
    chk("d_new_imm", oImm, 32'hABCDE000);
    chk1("d_new_valid", oValid, 1'b1);

    // Flush kills a held entry and frees its destination
    do_reset();
    iReady = 1'b0;
    iValid = 1'b1; iInstr = 32'h00400213; iPC = 32'h300;
    edge1();
    chk5("e_rd", oRd, 5'd4);
    iFlush = 1'b1; iInstr = 32'hABCDE2B7; iPC = 32'h304;
    @(negedge iClk);
    chk1("e_flush_ready", oReady, 1'b0);
    edge1();
    iFlush = 1'b0;
    chk1("e_flush_valid", oValid, 1'b0);
    chk("e_no_load", oInstr, 32'h00400213);
    iInstr = 32'h00020313; iPC = 32'h308; iRegA = 32'h77;
    @(negedge iClk);
    chk1("e_busy_cleared", oReady, 1'b1);
    edge1();
    iValid = 1'b0;
    chk1("e_valid", oValid, 1'b1);
    chk("e_opa", oOpA, 32'h77);

    // Async reset in the middle of a stall
    do_reset();
    iValid = 1'b1; iInstr = 32'h00500093; iPC = 32'h100; iRegA = 0; iRegB = 0;
    edge1();
    iReady = 1'b0;
    iInstr = 32'h00108133; iPC = 32'h104;
    @(negedge iClk);
    chk1("f_stall", oReady, 1'b0);
    nRst = 1'b0;
    #1;
    chk1("f_async_valid", oValid, 1'b0);
    edge1();
    nRst = 1'b1; iReady = 1'b1;
    @(negedge iClk);
    chk1("f_no_stall", oReady, 1'b1);
    edge1();
    iValid = 1'b0;
    chk1("f_valid", oValid, 1'b1);
    chk5("f_rd", oRd, 5'd2);

    // Randomised run against the reference model
    do_reset();
    model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = (k == 0) ? 32'd0 : $urandom();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins;
      int          bq[$];
      ins = $urandom();
      ins[6:0]   = op_tab[$urandom_range(0, 10)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      iInstr   = ins;
      iPC      = $urandom();
      iValid   = ($urandom_range(0, 9) < 7);
      iReady   = ($urandom_range(0, 9) < 7);
      iFlush   = ($urandom_range(0, 19) == 0);
      iWbWrite = ($urandom_range(0, 9) < 4);
      iWbData  = $urandom();
      bq.delete();
      for (int k = 1; k < 32; k++) if (m_busy[k]) bq.push_back(k);
      if (bq.size() > 0 && $urandom_range(0, 3) != 0)
        iWbAddr = 5'(bq[$urandom_range(0, bq.size() - 1)]);
      else
        iWbAddr = 5'($urandom_range(0, 7));
      iRegA = m_regs[ins[19:15]];
      iRegB = m_regs[ins[24:20]];
      model_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_operand_fetch.md
Name: rv_operand_fetch

Overview:
- RV32I decode/operand-fetch stage between instruction fetch and execute.
- Register file neighbour: drives the register file's two read addresses, consumes its read data, and bypasses the same-cycle writeback.
- Keeps a 32-entry busy scoreboard for RAW/WAW stalls and generates immediates.
- Presents a registered ID/EX entry with valid/ready handshakes on both sides.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
BYPASS_EN, 1, 1 = forward iWbData to operands when it matches a source; 0 = stall one extra cycle instead.

Ports:
iClk  in  1  clock, rising edge.
nRst  in  1  asynchronous active-low reset.
iValid  in  1  upstream instruction valid.
oReady  out  1  stage accepts the instruction this cycle.
iInstr  in  32  instruction word.
iPC  in  32  instruction address.
oAddrA  out  5  register file read address A = iInstr[19:15]; combinational.
oAddrB  out  5  register file read address B = iInstr[24:20]; combinational.
iRegA  in  32  register file read data A; combinational from oAddrA.
iRegB  in  32  register file read data B; combinational from oAddrB.
iWbWrite  in  1  writeback strobe; same net as the register file write enable.
iWbAddr  in  5  writeback destination.
iWbData  in  32  writeback data.
iFlush  in  1  kill the ID/EX entry and refuse input this cycle (EX branch redirect).
oValid  out  1  ID/EX entry valid.
iReady  in  1  execute stage accepts the entry.
oPC  out  32  registered PC.
oInstr  out  32  registered instruction.
oOpA  out  32  rs1 operand, or 0 when rs1 is unused.
oOpB  out  32  rs2 operand, or 0 when rs2 is unused.
oImm  out  32  sign-extended immediate.
oRd  out  5  destination register.
oRdWrite  out  1  entry writes oRd; never 1 when oRd = 0.
oIllegal  out  1  opcode not in the supported set.

Behaviour:
- Opcode classes (iInstr[6:0]):
  - R 0110011: rs1, rs2, rd; imm 0.
  - I 0010011/0000011/1100111: rs1, rd.
  - S 0100011: rs1, rs2.
  - B 1100011: rs1, rs2.
  - U 0110111/0010111: rd.
  - J 1101111: rd.
  - Anything else: no sources, no rd, imm 0, oIllegal = 1; the entry still flows.
- Immediates follow RV32I I/S/B/U/J encodings; sign bit is iInstr[31].
- Source use is ignored when its index is 0; x0 never stalls and reads 0.
- Scoreboard busy[31:1] resets to 0.
  - Set busy[rd] when an entry with oRdWrite = 1 is loaded.
  - Clear busy[iWbAddr] when iWbWrite = 1 and iWbAddr != 0.
  - Set and clear of the same index in one cycle: set wins.
- Hazard = iValid and any of:
  - a used source is busy and not bypassable this cycle;
  - rd is written and busy[rd] is set (WAW); a same-cycle writeback to rd clears this condition.
- A source is bypassable when BYPASS_EN = 1, iWbWrite = 1, and iWbAddr equals the source index; the operand then takes iWbData instead of iReg*.
- oReady = !iFlush && !hazard && (!oValid || iReady).
- Load occurs when iValid && oReady. On the next edge, all outputs are registered, oValid = 1, and busy is updated. Latency is 1 cycle.
- Without a load: if iReady && oValid, oValid falls to 0; otherwise outputs hold stable (held entry not changed by later writebacks).
- Flush: oValid goes to 0 on the next edge. If the killed entry had oRdWrite = 1, busy[oRd] is cleared; this takes priority over a set of the same bit. No load that cycle.
- Reset (async, nRst = 0): oValid = 0 and all registered outputs = 0; busy cleared. oReady follows its equation (0 while iFlush is high).
- Writeback to a non-busy register is legal and causes no state change beyond the clear.

Test Plan:
- Reset, then iInstr = 0x00500093 (addi x1,x0,5), iPC = 0x100, iReady = 1 -> next cycle oValid = 1, oOpA = 0, oImm = 5, oRd = 1, oRdWrite = 1; busy[1] = 1.
- Next, add x2,x1,x1 (0x00108133) with no writeback -> oReady = 0 and held; iWbWrite = 1, iWbAddr = 1, iWbData = 5 -> same cycle oReady = 1, next cycle oOpA = oOpB = 5. Repeat with BYPASS_EN = 0 -> one extra stall cycle, operands still 5.
- sw x2,-4(x3) (0xFE21AE23) with regfile x3 = 0x200, x2 = 7 -> oImm = 0xFFFFFFFC, oOpA = 0x200, oOpB = 7, oRdWrite = 0.
- Entry valid with iReady = 0 for 3 cycles, new iValid -> oReady = 0, outputs unchanged; iReady = 1 -> new entry loads next edge.
- Valid entry addi x4 held, then iFlush = 1 -> next cycle oValid = 0, busy[4] = 0, no load that cycle.
- Assert nRst low mid-stall with busy[1] set -> oValid = 0 immediately; after release, add x2,x1,x1 issues without stall.
